// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
//   Stall/flush sequencer for the 5-stage filter-core pipeline (IF ID EX MEM WB).
//   It drives every pipeline-register enable and flush:
//     - Freezes the whole pipe while a data-memory access is outstanding, and
//       aborts the access after MEM_TIMEOUT waiting cycles.
//     - Squashes wrong-path instructions after a taken branch in EX.
//     - Inserts a one-cycle bubble on a load-use hazard.
//
// Parameters
//   REG_AW       register-index width
//   MEM_TIMEOUT  max cycles in MEMWAIT before abort (1..255)
//   FLUSH_CYC    bubbles injected after a taken branch (1..3)
//
// Ports
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   sel_pc       in   branch taken, resolved in EX
//   ex_is_load   in   EX instruction is a load
//   ex_rd        in   EX destination register
//   id_rs1/2     in   ID source registers
//   id_use_rs1/2 in   ID instruction reads rs1/rs2
//   mem_req      in   MEM stage issues a data-memory access
//   mem_ready    in   data memory completes the access this cycle
//   pc_en, if_id_en, id_ex_en, ex_mem_en    out  register enables
//   if_id_flush, id_ex_flush                out  load NOP into IF/ID, ID/EX
//   mem_err      out  one-cycle pulse after a memory timeout abort
//   stall_cnt    out  saturating count of cycles with pc_en=0
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
   parameter int REG_AW      = 4,
   parameter int MEM_TIMEOUT = 255,
   parameter int FLUSH_CYC   = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              sel_pc,
   input  logic              ex_is_load,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic              id_use_rs1,
   input  logic              id_use_rs2,
   input  logic              mem_req,
   input  logic              mem_ready,
   output logic              pc_en,
   output logic              if_id_en,
   output logic              id_ex_en,
   output logic              ex_mem_en,
   output logic              if_id_flush,
   output logic              id_ex_flush,
   output logic              mem_err,
   output logic [15:0]       stall_cnt
);

   localparam logic [1:0] ST_RUN     = 2'd0;
   localparam logic [1:0] ST_MEMWAIT = 2'd1;
   localparam logic [1:0] ST_FLUSH   = 2'd2;

   logic [1:0]  state_reg, state_next;
   logic [7:0]  wcnt_reg, wcnt_next;
   logic [1:0]  fcnt_reg, fcnt_next;
   // Set when MEMWAIT was entered from FLUSH: the branch that caused the
   // flush has already been acted on, so it must not be flushed again.
   logic        from_flush_reg, from_flush_next;
   logic        mem_err_reg, mem_err_next;
   logic [15:0] stall_cnt_reg;

   logic pc_en_c, if_id_en_c, id_ex_en_c, ex_mem_en_c;
   logic if_id_flush_c, id_ex_flush_c;

   logic       mem_stall;
   logic [1:0] src_match;
   logic       load_use;

   logic [REG_AW-1:0] id_src [2];
   logic              id_use [2];

   assign id_src[0] = id_rs1;
   assign id_src[1] = id_rs2;
   assign id_use[0] = id_use_rs1;
   assign id_use[1] = id_use_rs2;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_src
         assign src_match[gi] = id_use[gi] & (id_src[gi] == ex_rd);
      end
   endgenerate

   assign load_use  = ex_is_load & (|src_match);
   assign mem_stall = mem_req & ~mem_ready;

   always_comb begin
      state_next      = state_reg;
      wcnt_next       = wcnt_reg;
      fcnt_next       = fcnt_reg;
      from_flush_next = from_flush_reg;
      mem_err_next    = 1'b0;
      pc_en_c         = 1'b1;
      if_id_en_c      = 1'b1;
      id_ex_en_c      = 1'b1;
      ex_mem_en_c     = 1'b1;
      if_id_flush_c   = 1'b0;
      id_ex_flush_c   = 1'b0;

      case (state_reg)
         ST_RUN: begin
            if (mem_stall) begin
               // A taken branch stays frozen in EX and is handled on exit.
               pc_en_c         = 1'b0;
               if_id_en_c      = 1'b0;
               id_ex_en_c      = 1'b0;
               ex_mem_en_c     = 1'b0;
               state_next      = ST_MEMWAIT;
               wcnt_next       = 8'd1;
               from_flush_next = 1'b0;
            end else if (sel_pc) begin
               if_id_flush_c = 1'b1;
               id_ex_flush_c = 1'b1;
               if (FLUSH_CYC > 1) begin
                  state_next = ST_FLUSH;
                  fcnt_next  = 2'd1;
               end
            end else if (load_use) begin
               // Hold PC and IF/ID, push a bubble into EX; the load moves on.
               pc_en_c       = 1'b0;
               if_id_en_c    = 1'b0;
               id_ex_flush_c = 1'b1;
            end
         end

         ST_MEMWAIT: begin
            if (mem_ready || (wcnt_reg == 8'(MEM_TIMEOUT))) begin
               // Completion or abort: the pipe advances this cycle, and a
               // branch held in EX during the wait is resolved now.
               mem_err_next = ~mem_ready;
               state_next   = ST_RUN;
               if (sel_pc && !from_flush_reg) begin
                  if_id_flush_c = 1'b1;
                  id_ex_flush_c = 1'b1;
                  if (FLUSH_CYC > 1) begin
                     state_next = ST_FLUSH;
                     fcnt_next  = 2'd1;
                  end
               end
            end else begin
               pc_en_c     = 1'b0;
               if_id_en_c  = 1'b0;
               id_ex_en_c  = 1'b0;
               ex_mem_en_c = 1'b0;
               wcnt_next   = wcnt_reg + 8'd1;
            end
         end

         ST_FLUSH: begin
            if (mem_stall) begin
               pc_en_c         = 1'b0;
               if_id_en_c      = 1'b0;
               id_ex_en_c      = 1'b0;
               ex_mem_en_c     = 1'b0;
               state_next      = ST_MEMWAIT;
               wcnt_next       = 8'd1;
               from_flush_next = 1'b1;
            end else begin
               if_id_flush_c = 1'b1;
               if (fcnt_reg == 2'(FLUSH_CYC - 1)) begin
                  state_next = ST_RUN;
               end else begin
                  fcnt_next = fcnt_reg + 2'd1;
               end
            end
         end

         default: begin
            state_next = ST_RUN;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= ST_RUN;
         wcnt_reg       <= 8'd0;
         fcnt_reg       <= 2'd0;
         from_flush_reg <= 1'b0;
         mem_err_reg    <= 1'b0;
         stall_cnt_reg  <= 16'd0;
      end else begin
         state_reg      <= state_next;
         wcnt_reg       <= wcnt_next;
         fcnt_reg       <= fcnt_next;
         from_flush_reg <= from_flush_next;
         mem_err_reg    <= mem_err_next;
         if (!pc_en_c && (stall_cnt_reg != 16'hFFFF)) begin
            stall_cnt_reg <= stall_cnt_reg + 16'd1;
         end
      end
   end

   // While reset is held the pipe must run freely regardless of inputs.
   assign pc_en       = ~rst_n | pc_en_c;
   assign if_id_en    = ~rst_n | if_id_en_c;
   assign id_ex_en    = ~rst_n | id_ex_en_c;
   assign ex_mem_en   = ~rst_n | ex_mem_en_c;
   assign if_id_flush = rst_n & if_id_flush_c;
   assign id_ex_flush = rst_n & id_ex_flush_c;
   assign mem_err     = mem_err_reg;
   assign stall_cnt   = stall_cnt_reg;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
//   Scoreboard bench: the stimulus process evaluates a behavioural model of the
//   hazard rules and queues the expected outputs for each cycle; a monitor on
//   the falling edge pops and compares against the DUT.
// -----------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;
   localparam int AW = 4;
   localparam int TO = 8;
   localparam int FC = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic sel_pc = 1'b0, ex_is_load = 1'b0;
   logic [AW-1:0] ex_rd = '0, id_rs1 = '0, id_rs2 = '0;
   logic id_use_rs1 = 1'b0, id_use_rs2 = 1'b0;
   logic mem_req = 1'b0, mem_ready = 1'b0;
   logic pc_en, if_id_en, id_ex_en, ex_mem_en;
   logic if_id_flush, id_ex_flush, mem_err;
   logic [15:0] stall_cnt;

   pipeline_hazard_ctrl #(.REG_AW(AW), .MEM_TIMEOUT(TO), .FLUSH_CYC(FC)) dut (
      .clk(clk), .rst_n(rst_n), .sel_pc(sel_pc), .ex_is_load(ex_is_load),
      .ex_rd(ex_rd), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
      .mem_req(mem_req), .mem_ready(mem_ready),
      .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
      .ex_mem_en(ex_mem_en), .if_id_flush(if_id_flush),
      .id_ex_flush(id_ex_flush), .mem_err(mem_err), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          cyc;
      logic [3:0]  en;     // {pc, if_id, id_ex, ex_mem}
      logic [1:0]  fl;     // {if_id, id_ex}
      logic        err;
      logic [15:0] sc;
   } exp_t;

   exp_t exp_q[$];
   int checks = 0;
   int errors = 0;
   int cyc_no = 0;
   int err_pulses = 0;

   // Behavioural model: time spent waiting on memory, bubbles still owed
   // after a branch, and whether the current wait interrupted a flush.
   bit waiting = 0;
   int waited = 0;
   int bubbles_left = 0;
   bit wait_interrupted_flush = 0;
   bit err_pending = 0;
   int stalls = 0;

   task automatic chk(input string name, input int act, input int expv);
      checks++;
      if (act != expv) begin
         errors++;
         $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc_no, act, expv);
      end
   endtask

   task automatic step(input logic r, input logic s, input logic ld,
                       input logic [AW-1:0] rd, input logic [AW-1:0] r1,
                       input logic [AW-1:0] r2, input logic u1, input logic u2,
                       input logic mq, input logic mr);
      exp_t e;
      bit nerr;
      bit hazard;
      rst_n = r; sel_pc = s; ex_is_load = ld; ex_rd = rd; id_rs1 = r1; id_rs2 = r2;
      id_use_rs1 = u1; id_use_rs2 = u2; mem_req = mq; mem_ready = mr;
      e.cyc = cyc_no; e.en = 4'b1111; e.fl = 2'b00;
      if (!r) begin
         e.err = 0; e.sc = 0;
         waiting = 0; waited = 0; bubbles_left = 0; wait_interrupted_flush = 0;
         err_pending = 0; stalls = 0;
      end else begin
         e.err = err_pending; e.sc = 16'(stalls);
         nerr = 0;
         hazard = ld && ((u1 && r1 == rd) || (u2 && r2 == rd));
         if (waiting) begin
            if (mr || waited == TO) begin
               nerr = !mr;
               waiting = 0;
               if (s && !wait_interrupted_flush) begin
                  e.fl = 2'b11;
                  bubbles_left = FC - 1;
               end
            end else begin
               e.en = 4'b0000;
               waited++;
            end
         end else if (mq && !mr) begin
            e.en = 4'b0000;
            waiting = 1; waited = 1;
            wait_interrupted_flush = (bubbles_left > 0);
            bubbles_left = 0;
         end else if (bubbles_left > 0) begin
            e.fl = 2'b10;
            bubbles_left--;
         end else if (s) begin
            e.fl = 2'b11;
            bubbles_left = FC - 1;
         end else if (hazard) begin
            e.en = 4'b0011;
            e.fl = 2'b01;
         end
         if (!e.en[3] && stalls < 65535) stalls++;
         err_pending = nerr;
      end
      exp_q.push_back(e);
      @(posedge clk); #1;
      cyc_no++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   // Monitor: one comparison set per cycle whenever an expectation is queued.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         if (mem_err) err_pulses++;
         $display("cyc %0d en=%b%b%b%b fl=%b%b err=%b sc=%0d", e.cyc, pc_en, if_id_en,
                  id_ex_en, ex_mem_en, if_id_flush, id_ex_flush, mem_err, stall_cnt);
         chk("pc_en", int'(pc_en), int'(e.en[3]));
         chk("if_id_en", int'(if_id_en), int'(e.en[2]));
         chk("id_ex_en", int'(id_ex_en), int'(e.en[1]));
         chk("ex_mem_en", int'(ex_mem_en), int'(e.en[0]));
         chk("if_id_flush", int'(if_id_flush), int'(e.fl[1]));
         chk("id_ex_flush", int'(id_ex_flush), int'(e.fl[0]));
         chk("mem_err", int'(mem_err), int'(e.err));
         chk("stall_cnt", int'(stall_cnt), int'(e.sc));
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog cyc=%0d actual=timeout expected=finish", cyc_no);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int p0;
      @(posedge clk); #1;
      // Reset held, then released with an idle pipe.
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0, 0, 0, 0, 1, 0);
      idle(10);
      // Load-use on rs1, then an rs2 hazard and a non-matching load.
      step(1, 0, 1, 3, 3, 0, 1, 0, 0, 0);
      idle(2);
      step(1, 0, 1, 5, 0, 5, 0, 1, 0, 0);
      step(1, 0, 1, 5, 5, 5, 0, 0, 0, 0);
      idle(1);
      // Taken branch: two flush cycles.
      step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      idle(3);
      // Memory wait of 5 stalled cycles then ready.
      for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
      idle(2);
      // Timeout: 8 stalled cycles, abort, one mem_err pulse.
      @(negedge clk); #1;
      p0 = err_pulses;
      @(posedge clk); #1;
      for (int i = 0; i < 9; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      idle(3);
      @(negedge clk); #1;
      chk("timeout_pulses", err_pulses - p0, 1);
      @(posedge clk); #1;
      // Branch and stall together: stall wins, flush on the ready cycle.
      for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0, 0, 0, 0, 1, 0);
      step(1, 1, 0, 0, 0, 0, 0, 0, 1, 1);
      idle(3);
      // Stall arriving in FLUSH: no re-flush afterwards.
      step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      step(1, 1, 0, 0, 0, 0, 0, 0, 1, 0);
      step(1, 1, 0, 0, 0, 0, 0, 0, 1, 1);
      idle(2);
      // Reset asserted mid-wait forces enables high immediately.
      for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      rst_n = 1'b0;
      #1;
      chk("async_rst_pc_en", int'(pc_en), 1);
      chk("async_rst_ex_mem_en", int'(ex_mem_en), 1);
      step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      idle(3);
      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         logic r, s, ld, u1, u2, mq, mr;
         logic [AW-1:0] rd, r1, r2;
         r  = ($urandom_range(0, 199) != 0);
         s  = ($urandom_range(0, 99) < 15);
         ld = ($urandom_range(0, 99) < 40);
         rd = AW'($urandom_range(0, 3));
         r1 = AW'($urandom_range(0, 3));
         r2 = AW'($urandom_range(0, 3));
         u1 = $urandom_range(0, 1) != 0;
         u2 = $urandom_range(0, 1) != 0;
         mq = ($urandom_range(0, 99) < 25);
         mr = (i < 1500) ? ($urandom_range(0, 99) < 40) : ($urandom_range(0, 99) < 8);
         step(r, s, ld, rd, r1, r2, u1, u2, mq, mr);
      end
      idle(2);
      @(negedge clk); #1;
      chk("queue_drained", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
